// File: rtl/io_mmio_ctrl.sv
// io_mmio_ctrl: memory-mapped IO unit (UART TX holding register, UART RX FIFO, counters).
// Optional macro IO_COUNTERS_EN builds the cycle/instruction counters at offsets 0x10/0x14/0x18.
module io_mmio_ctrl #(
    parameter int RX_DEPTH = 4,
    parameter int CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  io_trans,
    input  logic        io_recv,
    input  logic [31:0] addr,
    input  logic [31:0] mem_in,
    input  logic        inst_retire,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] io_rdata
);
    localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(RX_DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1'b1);
    localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(1'b0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(1'b0);

    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_RXDATA = 8'h04;
    localparam logic [7:0] OFF_TXDATA = 8'h08;
    localparam logic [7:0] OFF_CYCLE  = 8'h10;
    localparam logic [7:0] OFF_INSTR  = 8'h14;
    localparam logic [7:0] OFF_CLEAR  = 8'h18;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_PEND = 1'b1
    } tx_state_t;

    logic [7:0]  offset_s;
    logic        store_s;
    logic [31:0] rdata_s;
    logic [31:0] cyc_rd_s;
    logic [31:0] inst_rd_s;
    logic        unused_s;

    assign offset_s = addr[7:0];
    assign store_s  = |io_trans;
    assign unused_s = ^{addr[31:8], mem_in[31:8], io_trans[3:1], inst_retire, store_s};

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem_r [RX_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] occ_r;
    logic             fifo_empty_s;
    logic             push_s;
    logic             pop_s;

    // rx_ready comes from the registered count only, so a full FIFO never
    // accepts a byte even when a pop happens in the same cycle.
    assign fifo_empty_s = (occ_r == OCC_ZERO);
    assign rx_ready     = (occ_r != OCC_FULL);
    assign push_s       = rx_valid & rx_ready;
    assign pop_s        = io_recv & (offset_s == OFF_RXDATA) & ~fifo_empty_s;

    // FIFO storage, circular pointers and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            occ_r    <= OCC_ZERO;
            for (int i = 0; i < RX_DEPTH; i++) begin
                fifo_mem_r[i] <= 8'h00;
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= rx_data;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_ONE;
                2'b01:   occ_r <= occ_r - OCC_ONE;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit holding register
    // ------------------------------------------------------------------
    tx_state_t tx_state_r;
    tx_state_t tx_state_s;
    logic      tx_wr_s;
    logic      tx_load_s;

    assign tx_wr_s = io_trans[0] & (offset_s == OFF_TXDATA);

    // TX next state: writes while a byte is pending are dropped
    always_comb begin
        tx_state_s = tx_state_r;
        tx_load_s  = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                if (tx_wr_s) begin
                    tx_state_s = TX_PEND;
                    tx_load_s  = 1'b1;
                end else begin
                    tx_state_s = TX_IDLE;
                end
            end
            TX_PEND: begin
                if (tx_ready) begin
                    tx_state_s = TX_IDLE;
                end else begin
                    tx_state_s = TX_PEND;
                end
            end
            default: begin
                tx_state_s = TX_IDLE;
            end
        endcase
    end

    // TX state, valid flag and data register
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            tx_state_r <= tx_state_s;
            tx_valid   <= (tx_state_s == TX_PEND);
            if (tx_load_s) begin
                tx_data <= mem_in[7:0];
            end else begin
                tx_data <= tx_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Cycle and instruction counters
    // ------------------------------------------------------------------
`ifdef IO_COUNTERS_EN
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);

    logic [CNT_W-1:0] cyc_cnt_r;
    logic [CNT_W-1:0] inst_cnt_r;
    logic             clr_s;

    assign clr_s     = store_s & (offset_s == OFF_CLEAR);
    assign cyc_rd_s  = 32'(cyc_cnt_r);
    assign inst_rd_s = 32'(inst_cnt_r);

    // Free-running counters; a clear write wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_r  <= CNT_ZERO;
            inst_cnt_r <= CNT_ZERO;
        end else if (clr_s) begin
            cyc_cnt_r  <= CNT_ZERO;
            inst_cnt_r <= CNT_ZERO;
        end else begin
            cyc_cnt_r <= cyc_cnt_r + CNT_ONE;
            if (inst_retire) begin
                inst_cnt_r <= inst_cnt_r + CNT_ONE;
            end else begin
                inst_cnt_r <= inst_cnt_r;
            end
        end
    end
`else
    assign cyc_rd_s  = 32'h0000_0000;
    assign inst_rd_s = 32'h0000_0000;
`endif

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------

    // Load data select; sees state before any update at the coming edge
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (offset_s)
            OFF_STATUS: rdata_s = {30'h0000_0000, ~fifo_empty_s, ~tx_valid};
            OFF_RXDATA: begin
                if (fifo_empty_s) begin
                    rdata_s = 32'h0000_0000;
                end else begin
                    rdata_s = {24'h00_0000, fifo_mem_r[rd_ptr_r]};
                end
            end
            OFF_CYCLE:  rdata_s = cyc_rd_s;
            OFF_INSTR:  rdata_s = inst_rd_s;
            default:    rdata_s = 32'h0000_0000;
        endcase
    end

    // Registered load result, held between loads
    always_ff @(posedge clk) begin
        if (rst) begin
            io_rdata <= 32'h0000_0000;
        end else if (io_recv) begin
            io_rdata <= rdata_s;
        end else begin
            io_rdata <= io_rdata;
        end
    end

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Scoreboard bench for io_mmio_ctrl: loads push expected data, a monitor checks io_rdata.
module tb_io_mmio_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  io_trans;
    logic        io_recv;
    logic [31:0] addr;
    logic [31:0] mem_in;
    logic        inst_retire;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] io_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] exp_q[$];

`ifdef IO_COUNTERS_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    io_mmio_ctrl #(.RX_DEPTH(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .io_trans(io_trans), .io_recv(io_recv),
        .addr(addr), .mem_in(mem_in), .inst_retire(inst_retire),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .io_rdata(io_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Advance to the next falling edge and return all per-cycle inputs to idle
    task automatic tick();
        @(negedge clk);
        io_trans    = 4'h0;
        io_recv     = 1'b0;
        addr        = 32'h8000_0000;
        mem_in      = 32'h0;
        inst_retire = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
    endtask

    task automatic ld(input logic [7:0] off, input logic [31:0] exp);
        io_recv = 1'b1;
        addr    = {24'h80_0000, off};
        exp_q.push_back(exp);
    endtask

    task automatic st(input logic [7:0] off, input logic [31:0] data, input logic [3:0] trans);
        io_trans = trans;
        addr     = {24'h80_0000, off};
        mem_in   = data;
    endtask

    task automatic px(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    // Monitor: io_rdata is checked one edge after each sampled load
    initial begin
        logic was_load;
        forever begin
            @(posedge clk);
            was_load = io_recv && !rst;
            #1;
            if (was_load) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL rdata_unexpected: got 0x%08h expected no load", io_rdata);
                end else begin
                    chk("rdata", io_rdata, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        tx_ready = 1'b0;
        io_trans = 4'h0; io_recv = 1'b0; addr = 32'h8000_0000; mem_in = 32'h0;
        inst_retire = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_rdata", io_rdata, 32'h0);
        chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("reset_tx_data", {24'h0, tx_data}, 32'h0);
        chk("reset_rx_ready", {31'h0, rx_ready}, 32'h1);
        ld(8'h00, 32'h1);

        // TX: 0x41 held four cycles, 0x42 dropped while pending
        tick(); st(8'h08, 32'h41, 4'b0001);
        tick(); chk("tx_valid_c1", {31'h0, tx_valid}, 32'h1);
                chk("tx_data_c1", {24'h0, tx_data}, 32'h41);
                st(8'h08, 32'h42, 4'b0001);
        tick(); chk("tx_data_c2", {24'h0, tx_data}, 32'h41);
                ld(8'h00, 32'h0);
        tick(); chk("tx_data_c3", {24'h0, tx_data}, 32'h41);
        tick(); chk("tx_valid_c4", {31'h0, tx_valid}, 32'h1);
                chk("tx_data_c4", {24'h0, tx_data}, 32'h41);
                tx_ready = 1'b1;
        tick(); chk("tx_valid_drop", {31'h0, tx_valid}, 32'h0);
                tx_ready = 1'b0;
                st(8'h08, 32'h99, 4'b0010);
        tick(); chk("tx_lane_mask", {31'h0, tx_valid}, 32'h0);
                st(8'h08, 32'h43, 4'b0001);
        tick(); chk("tx_data_new", {24'h0, tx_data}, 32'h43);
                chk("tx_valid_new", {31'h0, tx_valid}, 32'h1);
                tx_ready = 1'b1;
        tick(); chk("tx_valid_drop2", {31'h0, tx_valid}, 32'h0);
                tx_ready = 1'b0;
                ld(8'h00, 32'h1);

        // RX overflow and drain
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 3) chk("rx_ready_3", {31'h0, rx_ready}, 32'h1);
            if (i == 4) chk("rx_ready_full", {31'h0, rx_ready}, 32'h0);
            px(8'(8'h11 * (i + 1)));
        end
        tick(); ld(8'h00, 32'h3);
        for (int i = 0; i < 4; i++) begin
            tick(); ld(8'h04, 32'(8'(8'h11 * (i + 1))));
        end
        tick(); ld(8'h04, 32'h0);
        tick(); ld(8'h00, 32'h1);
        tick();
        tick(); chk("rdata_hold", io_rdata, 32'h1);
                chk("rx_ready_drained", {31'h0, rx_ready}, 32'h1);
                ld(8'h20, 32'h0);

        // Empty FIFO with same-cycle push and pop
        tick(); px(8'h7E); ld(8'h04, 32'h0);
        tick(); ld(8'h04, 32'h7E);
        tick(); ld(8'h04, 32'h0);

        // Counters
        tick(); st(8'h18, 32'h0, 4'b1111);
        for (int i = 0; i < 100; i++) begin
            tick(); inst_retire = (i < 60);
        end
        tick(); ld(8'h14, CNT_ON ? 32'd60 : 32'd0);
        tick(); ld(8'h10, CNT_ON ? 32'd101 : 32'd0);
        tick(); st(8'h18, 32'h0, 4'b0001); inst_retire = 1'b1;
        tick();
        tick(); ld(8'h14, 32'd0);
        tick(); ld(8'h10, CNT_ON ? 32'd2 : 32'd0);

        // FIFO held at two entries across pointer wrap
        tick(); px(8'hA0);
        tick(); px(8'hA1);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 10) chk("rx_ready_wrap", {31'h0, rx_ready}, 32'h1);
            px(8'(8'hA2 + i));
            ld(8'h04, 32'(8'(8'hA0 + i)));
        end
        tick(); ld(8'h00, 32'h3);
        tick(); ld(8'h04, 32'hB4);
        tick(); ld(8'h04, 32'hB5);
        tick(); ld(8'h04, 32'h0);

        // Reset mid-transfer
        tick(); st(8'h08, 32'h5A, 4'b0001); px(8'h66);
        tick(); chk("tx_valid_pre_rst", {31'h0, tx_valid}, 32'h1);
                rst = 1'b1;
        tick(); rst = 1'b0;
        tick(); chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
                chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
                chk("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
                ld(8'h00, 32'h1);
        tick(); ld(8'h04, 32'h0);
        tick();
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
